// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong paddle input path.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } chan_state_t;

  localparam int BTN_P1_UP = 0;
  localparam int BTN_P1_DN = 1;
  localparam int BTN_P2_UP = 2;
  localparam int BTN_P2_DN = 3;

  // Counter width sized by the largest timing parameter; limit-1 always fits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debouncer and press/auto-repeat FSM.
module btn_channel
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic game_en,
  input  logic raw,
  output logic clean,
  output logic pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] cnt;
  chan_state_t   state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
      db_cnt   <= '0;
      clean    <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      if (sync_reg[1] == clean) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        clean  <= ~clean;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Raw pulse is combinational so the registered output stage adds only one cycle.
  always_comb begin
    pulse = 1'b0;
    if (game_en && clean) begin
      case (state)
        IDLE:    pulse = 1'b1;
        DELAY:   pulse = (cnt == DELAY_LAST);
        REPEAT:  pulse = (cnt == RATE_LAST);
        default: pulse = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!game_en) begin
      state <= clean ? LOCK : IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (clean) state <= DELAY;
        end
        DELAY: begin
          if (!clean) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DELAY_LAST) begin
            state <= REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!clean) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == RATE_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt <= '0;
          if (!clean) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/paddle_input_ctrl.sv
// Four paddle buttons: per-button channels plus per-player up/down conflict resolution.
module paddle_input_ctrl
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_en,
  input  logic [3:0] btn_raw,
  output logic       p1_up,
  output logic       p1_dn,
  output logic       p2_up,
  output logic       p2_dn,
  output logic [3:0] btn_clean
);

  logic [3:0] raw_pulse;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
      ) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .game_en(game_en),
        .raw    (btn_raw[gi]),
        .clean  (btn_clean[gi]),
        .pulse  (raw_pulse[gi])
      );
    end
  endgenerate

  // Simultaneous up and down pulses for one player cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_up <= 1'b0;
      p1_dn <= 1'b0;
      p2_up <= 1'b0;
      p2_dn <= 1'b0;
    end else begin
      p1_up <= raw_pulse[BTN_P1_UP] & ~raw_pulse[BTN_P1_DN];
      p1_dn <= raw_pulse[BTN_P1_DN] & ~raw_pulse[BTN_P1_UP];
      p2_up <= raw_pulse[BTN_P2_UP] & ~raw_pulse[BTN_P2_DN];
      p2_dn <= raw_pulse[BTN_P2_DN] & ~raw_pulse[BTN_P2_UP];
    end
  end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Scoreboard bench for paddle_input_ctrl with short timing parameters.
module tb_paddle_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_en = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic       p1_up, p1_dn, p2_up, p2_dn;
  logic [3:0] btn_clean;

  paddle_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .game_en  (game_en),
    .btn_raw  (btn_raw),
    .p1_up    (p1_up),
    .p1_dn    (p1_dn),
    .p2_up    (p2_up),
    .p2_dn    (p2_dn),
    .btn_clean(btn_clean)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every nonzero output cycle must match the head of the queue.
  always @(negedge clk) begin
    logic [3:0] outs;
    exp_t e;
    outs = {p2_dn, p2_up, p1_dn, p1_up};
    if (outs != 4'b0000) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse rel_cycle=%0d got=%b required=none", cyc - base, outs);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.mask != outs) begin
          failures++;
          $display("FAIL pulse rel_cycle=%0d got=%b required rel_cycle=%0d mask=%b",
                   cyc - base, outs, e.cyc - base, e.mask);
        end else begin
          $display("pulse ok rel_cycle=%0d mask=%b", cyc - base, outs);
        end
      end
    end
  end

  task automatic goto(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_test();
    @(posedge clk);
    #1;
    base = cyc;
  endtask

  task automatic expect_pulse(input int k, input logic [3:0] m);
    exp_t e;
    e.cyc  = base + k;
    e.mask = m;
    q.push_back(e);
  endtask

  task automatic check4(input string name, input logic [3:0] got, input logic [3:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s rel_cycle=%0d got=%b required=%b", name, cyc - base, got, req);
    end else begin
      $display("check ok %s rel_cycle=%0d value=%b", name, cyc - base, got);
    end
  endtask

  task automatic end_test(input string name);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_pulses got=%0d_left required=0", name, q.size());
      q.delete();
    end else begin
      $display("check ok %s all expected pulses seen", name);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    btn_raw = 4'b0000;
    game_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    // Reset state
    #2;
    check4("reset_outputs", {p2_dn, p2_up, p1_dn, p1_up}, 4'b0000);
    check4("reset_clean", btn_clean, 4'b0000);
    do_reset();

    // 1: press/hold p1_up, raw high cycles 0..19 (clean falls at 26)
    start_test();
    btn_raw = 4'b0001;
    expect_pulse(7, 4'b0001);
    expect_pulse(17, 4'b0001);
    expect_pulse(20, 4'b0001);
    expect_pulse(23, 4'b0001);
    expect_pulse(26, 4'b0001);
    goto(5);  check4("t1_clean_before", btn_clean, 4'b0000);
    goto(6);  check4("t1_clean_rise", btn_clean, 4'b0001);
    goto(20); btn_raw = 4'b0000;
    goto(26); check4("t1_clean_fall", btn_clean, 4'b0000);
    goto(35); end_test("t1");
    do_reset();

    // 2: 3-cycle glitch never reaches the clean level
    start_test();
    btn_raw = 4'b0001;
    goto(3); btn_raw = 4'b0000;
    for (int k = 4; k <= 12; k += 4) begin
      goto(k);
      check4("t2_clean_glitch", btn_clean, 4'b0000);
    end
    goto(20); end_test("t2");
    do_reset();

    // 3: p1 up+down cancel; p2_dn in parallel still pulses
    start_test();
    btn_raw = 4'b1011;
    expect_pulse(7, 4'b1000);
    expect_pulse(17, 4'b1000);
    expect_pulse(20, 4'b1000);
    expect_pulse(23, 4'b1000);
    expect_pulse(26, 4'b1000);
    goto(6);  check4("t3_clean", btn_clean, 4'b1011);
    goto(20); btn_raw = 4'b0000;
    goto(35); end_test("t3");
    do_reset();

    // 4: game_en drop while holding locks out until release and re-press
    start_test();
    btn_raw = 4'b0100;
    expect_pulse(7, 4'b0100);
    goto(12); game_en = 1'b0;
    goto(15); game_en = 1'b1;
    goto(25); btn_raw = 4'b0000;
    goto(40); btn_raw = 4'b0100;
    expect_pulse(47, 4'b0100);
    goto(50); btn_raw = 4'b0000;
    goto(60); end_test("t4");
    do_reset();

    // 5: reset mid-hold clears everything; press is re-detected afterwards
    start_test();
    btn_raw = 4'b1000;
    expect_pulse(7, 4'b1000);
    goto(8); check4("t5_clean_held", btn_clean, 4'b1000);
    goto(9); rst_n = 1'b0;
    #1;
    check4("t5_reset_outputs", {p2_dn, p2_up, p1_dn, p1_up}, 4'b0000);
    check4("t5_reset_clean", btn_clean, 4'b0000);
    goto(10); rst_n = 1'b1;
    expect_pulse(17, 4'b1000);
    expect_pulse(27, 4'b1000);
    expect_pulse(30, 4'b1000);
    goto(31); btn_raw = 4'b0000;
    expect_pulse(33, 4'b1000);
    expect_pulse(36, 4'b1000);
    goto(45); end_test("t5");
    do_reset();

    // 6: release during DELAY: single press pulse only
    start_test();
    btn_raw = 4'b0001;
    expect_pulse(7, 4'b0001);
    goto(5);  btn_raw = 4'b0000;
    goto(10); check4("t6_clean_still_high", btn_clean, 4'b0001);
    goto(11); check4("t6_clean_fall", btn_clean, 4'b0000);
    goto(30); end_test("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
